// File: rtl/hazard_pkg.sv
// Shared opcode constants, source-use decode and FSM state type for the
// stalling RV32I hazard control.
package hazard_pkg;

   localparam logic [4:0] OPC_LUI    = 5'b01101;
   localparam logic [4:0] OPC_AUIPC  = 5'b00101;
   localparam logic [4:0] OPC_JAL    = 5'b11011;
   localparam logic [4:0] OPC_JALR   = 5'b11001;
   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_LOAD   = 5'b00000;
   localparam logic [4:0] OPC_STORE  = 5'b01000;
   localparam logic [4:0] OPC_OPIMM  = 5'b00100;
   localparam logic [4:0] OPC_OP     = 5'b01100;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      FLUSH = 2'd2
   } hz_state_t;

   function automatic logic uses_rs1(input logic [4:0] opcode);
      return !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
   endfunction

   function automatic logic uses_rs2(input logic [4:0] opcode);
      return (opcode == OPC_BRANCH) || (opcode == OPC_STORE) || (opcode == OPC_OP);
   endfunction

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter: counts clocks with i_inc high and holds at all-ones.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_inc,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_inc && (r_count != {W{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// RAW-hazard / taken-branch stall and flush control for the no-forwarding
// RV32I pipeline, with a shadow MEM/WB rd pipeline and perf counters.
module hazard_stall_ctrl
   import hazard_pkg::*;
#(
   parameter bit RF_WRITE_THROUGH = 1'b0,
   parameter int CNT_W            = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_opcode,
   input  logic [4:0]       ex_rd,
   input  logic             ex_rd_wren,
   input  logic             ex_br_taken,
   output logic             pc_stall,
   output logic             ifid_stall,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   logic [4:0] r_mem_rd;
   logic       r_mem_wren;
   logic [4:0] r_wb_rd;
   logic       r_wb_wren;
   hz_state_t  r_state;
   hz_state_t  w_state_next;

   logic [4:0] w_src [2];
   logic [1:0] w_src_used;
   logic [1:0] w_src_hazard;
   logic       w_hazard;
   logic       w_stall;

   function automatic logic stage_match(input logic wren, input logic [4:0] rd,
                                        input logic [4:0] r);
      return wren && (rd == r) && (r != 5'd0);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem_rd   <= '0;
         r_mem_wren <= 1'b0;
         r_wb_rd    <= '0;
         r_wb_wren  <= 1'b0;
      end else begin
         r_mem_rd   <= ex_rd;
         r_mem_wren <= ex_rd_wren;
         r_wb_rd    <= r_mem_rd;
         r_wb_wren  <= r_mem_wren;
      end
   end

   assign w_src[0]      = id_rs1;
   assign w_src[1]      = id_rs2;
   assign w_src_used[0] = uses_rs1(id_opcode);
   assign w_src_used[1] = uses_rs2(id_opcode);

   // WB matches are harmless when the register file forwards its write port.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_src
         assign w_src_hazard[gi] = w_src_used[gi] &&
            (stage_match(ex_rd_wren, ex_rd, w_src[gi]) ||
             stage_match(r_mem_wren, r_mem_rd, w_src[gi]) ||
             (!RF_WRITE_THROUGH && stage_match(r_wb_wren, r_wb_rd, w_src[gi])));
      end
   endgenerate

   assign w_hazard = |w_src_hazard;
   assign w_stall  = w_hazard && !ex_br_taken;

   always_comb begin
      pc_stall   = 1'b0;
      ifid_stall = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      if (rst_n) begin
         if (ex_br_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end else if (w_hazard) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
         end
      end
   end

   // State is observational only; the controls above never look at it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         RUN:     w_state_next = ex_br_taken ? FLUSH : (w_hazard ? STALL : RUN);
         STALL:   w_state_next = ex_br_taken ? FLUSH : (w_hazard ? STALL : RUN);
         FLUSH:   w_state_next = ex_br_taken ? FLUSH : RUN;
         default: w_state_next = RUN;
      endcase
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_inc   (w_stall),
      .o_count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_inc   (ex_br_taken),
      .o_count (flush_cnt)
   );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench: one instance without RF write-through (32-bit counters)
// and one with write-through (4-bit counters), driven in lockstep.
module tb_hazard_stall_ctrl;
   import hazard_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] id_rs1 = '0;
   logic [4:0] id_rs2 = '0;
   logic [4:0] id_opcode = OPC_OPIMM;
   logic [4:0] ex_rd = '0;
   logic       ex_rd_wren = 1'b0;
   logic       ex_br_taken = 1'b0;

   logic        a_pc_stall, a_ifid_stall, a_ifid_flush, a_idex_flush;
   logic [31:0] a_stall_cnt, a_flush_cnt;
   logic        b_pc_stall, b_ifid_stall, b_ifid_flush, b_idex_flush;
   logic [3:0]  b_stall_cnt, b_flush_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.RF_WRITE_THROUGH(1'b0), .CNT_W(32)) dut_a (
      .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_opcode(id_opcode), .ex_rd(ex_rd), .ex_rd_wren(ex_rd_wren),
      .ex_br_taken(ex_br_taken), .pc_stall(a_pc_stall), .ifid_stall(a_ifid_stall),
      .ifid_flush(a_ifid_flush), .idex_flush(a_idex_flush),
      .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
   );

   hazard_stall_ctrl #(.RF_WRITE_THROUGH(1'b1), .CNT_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_opcode(id_opcode), .ex_rd(ex_rd), .ex_rd_wren(ex_rd_wren),
      .ex_br_taken(ex_br_taken), .pc_stall(b_pc_stall), .ifid_stall(b_ifid_stall),
      .ifid_flush(b_ifid_flush), .idex_flush(b_idex_flush),
      .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   // Control vector order: {pc_stall, ifid_stall, ifid_flush, idex_flush}
   localparam logic [3:0] C_NONE  = 4'b0000;
   localparam logic [3:0] C_STALL = 4'b1101;
   localparam logic [3:0] C_FLUSH = 4'b0011;

   function automatic logic [31:0] ctl_a();
      return {28'd0, a_pc_stall, a_ifid_stall, a_ifid_flush, a_idex_flush};
   endfunction

   function automatic logic [31:0] ctl_b();
      return {28'd0, b_pc_stall, b_ifid_stall, b_ifid_flush, b_idex_flush};
   endfunction

   task automatic drive(input logic [4:0] opc, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic wren, input logic br);
      id_opcode   = opc;
      id_rs1      = rs1;
      id_rs2      = rs2;
      ex_rd       = rd;
      ex_rd_wren  = wren;
      ex_br_taken = br;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 3; i++) begin
         drive(OPC_OPIMM, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
         tick();
      end
   endtask

   initial begin
      // Reset state
      @(negedge clk);
      drive(OPC_OP, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0);
      check("rst ctl a", ctl_a(), {28'd0, C_NONE});
      check("rst ctl b", ctl_b(), {28'd0, C_NONE});
      check("rst stall_cnt a", a_stall_cnt, 32'd0);
      check("rst flush_cnt b", {28'd0, b_flush_cnt}, 32'd0);
      drive(OPC_OPIMM, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      tick();
      rst_n = 1'b1;
      #1;

      // Back-to-back dependency, rs1==rs2==x5: 3 stalls (a), 2 stalls (b)
      drive(OPC_OP, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0);
      check("raw ex a", ctl_a(), {28'd0, C_STALL});
      check("raw ex b", ctl_b(), {28'd0, C_STALL});
      tick();
      drive(OPC_OP, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
      check("raw mem a", ctl_a(), {28'd0, C_STALL});
      check("raw mem b", ctl_b(), {28'd0, C_STALL});
      tick();
      check("raw wb a", ctl_a(), {28'd0, C_STALL});
      check("raw wb b", ctl_b(), {28'd0, C_NONE});
      tick();
      check("raw clear a", ctl_a(), {28'd0, C_NONE});
      check("raw stall_cnt a", a_stall_cnt, 32'd3);
      check("raw stall_cnt b", {28'd0, b_stall_cnt}, 32'd2);
      drain();

      // x0 never hazards
      drive(OPC_OP, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
      check("x0 ex a", ctl_a(), {28'd0, C_NONE});
      tick();
      check("x0 mem a", ctl_a(), {28'd0, C_NONE});
      drain();
      check("x0 stall_cnt a", a_stall_cnt, 32'd3);

      // LUI does not read rs1/rs2
      drive(OPC_LUI, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0);
      check("lui a", ctl_a(), {28'd0, C_NONE});
      check("lui b", ctl_b(), {28'd0, C_NONE});
      drain();

      // Store rs2=x9 against MEM producer
      drive(OPC_OPIMM, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
      check("st prod a", ctl_a(), {28'd0, C_NONE});
      tick();
      drive(OPC_STORE, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0);
      check("st mem a", ctl_a(), {28'd0, C_STALL});
      check("st mem b", ctl_b(), {28'd0, C_STALL});
      tick();
      check("st wb a", ctl_a(), {28'd0, C_STALL});
      check("st wb b", ctl_b(), {28'd0, C_NONE});
      tick();
      check("st clear a", ctl_a(), {28'd0, C_NONE});
      check("st stall_cnt a", a_stall_cnt, 32'd5);
      check("st stall_cnt b", {28'd0, b_stall_cnt}, 32'd3);
      drain();

      // Branch beats hazard
      drive(OPC_OP, 5'd4, 5'd0, 5'd4, 1'b1, 1'b1);
      check("br ctl a", ctl_a(), {28'd0, C_FLUSH});
      check("br ctl b", ctl_b(), {28'd0, C_FLUSH});
      tick();
      drive(OPC_OPIMM, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      check("br flush_cnt a", a_flush_cnt, 32'd1);
      check("br stall_cnt a", a_stall_cnt, 32'd5);
      check("br state flush", {30'd0, dut_a.r_state}, {30'd0, FLUSH});
      tick();
      check("br state run", {30'd0, dut_a.r_state}, {30'd0, RUN});
      drain();

      // Reset mid-stall
      drive(OPC_OP, 5'd8, 5'd0, 5'd8, 1'b1, 1'b0);
      check("rm stall a", ctl_a(), {28'd0, C_STALL});
      rst_n = 1'b0;
      #1;
      check("rm ctl a", ctl_a(), {28'd0, C_NONE});
      check("rm stall_cnt a", a_stall_cnt, 32'd0);
      check("rm flush_cnt a", a_flush_cnt, 32'd0);
      tick();
      rst_n = 1'b1;
      drive(OPC_OP, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0);
      check("rm after a", ctl_a(), {28'd0, C_NONE});
      check("rm after b", ctl_b(), {28'd0, C_NONE});
      tick();
      check("rm state", {30'd0, dut_a.r_state}, {30'd0, RUN});
      drain();

      // Saturation: 17 stall cycles with a 4-bit counter
      for (int i = 0; i < 17; i++) begin
         drive(OPC_OP, 5'd3, 5'd0, 5'd3, 1'b1, 1'b0);
         tick();
         if (i == 14) check("sat reach b", {28'd0, b_stall_cnt}, 32'd15);
      end
      check("sat hold b", {28'd0, b_stall_cnt}, 32'd15);
      check("sat ref a", a_stall_cnt, 32'd17);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Consumer side of the ID/EX pipeline register in the stalling (no-forwarding) RV32I pipeline.
- Takes the EX-stage destination info from the ID/EX register outputs and the decoding ID instruction's sources.
- Keeps a shadow rd/wren pipeline for MEM and WB, detects RAW hazards and taken-branch redirects, and drives stall/flush controls back to PC, IF/ID and ID/EX.
- Also provides a saturating stall-cycle performance counter.

Parameters:
- RF_WRITE_THROUGH, 0, 1 = register file returns WB write data on same-cycle read, so a WB-stage match is not a hazard.
- CNT_W, 32, width of the stall/flush performance counters.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- id_rs1  in  5  rs1 of the instruction in ID
- id_rs2  in  5  rs2 of the instruction in ID
- id_opcode  in  5  instr[6:2] of the instruction in ID
- ex_rd  in  5  rd of the instruction in EX (ID/EX register output)
- ex_rd_wren  in  1  rd write enable of the instruction in EX (ID/EX register output)
- ex_br_taken  in  1  branch/jump in EX redirects the PC this cycle
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID register
- ifid_flush  out  1  load NOP into IF/ID
- idex_flush  out  1  load bubble into ID/EX (rd_wren=0, mem_wren=0)
- stall_cnt  out  CNT_W  cycles spent in a RAW stall, saturating
- flush_cnt  out  CNT_W  taken-branch flushes, saturating

Behaviour:
- Source use is decoded from id_opcode via the package:
  - rs1 is used unless LUI(01101), AUIPC(00101) or JAL(11011).
  - rs2 is used only for BRANCH(11000), STORE(01000) and OP(01100).
- Shadow pipeline, registered every cycle with no enable:
  - mem_rd <= ex_rd; mem_wren <= ex_rd_wren.
  - wb_rd <= mem_rd; wb_wren <= mem_wren.
- Stage match: match_S(r) = S_wren && S_rd == r && r != 0.
- RAW hazard (combinational), true for any used source r:
  - match_EX(r) or match_MEM(r), or
  - match_WB(r) when RF_WRITE_THROUGH=0.
- Priority: ex_br_taken beats a RAW hazard.
  - Branch: ifid_flush=1, idex_flush=1, pc_stall=0, ifid_stall=0.
  - Else hazard: pc_stall=1, ifid_stall=1, idex_flush=1, ifid_flush=0.
  - Else all four controls are 0.
- All four controls are forced to 0 while rst_n=0.
- Latency:
  - Controls are same-cycle combinational, so the bubble enters EX on the next edge.
  - The stall clears automatically as the producer drains through the shadow stages.
  - Worst case is a back-to-back dependency: 3 stall cycles with RF_WRITE_THROUGH=0, 2 with RF_WRITE_THROUGH=1.
- FSM (registered; for counting and visibility only, never gates the controls):
  - RUN -> STALL when hazard && !ex_br_taken.
  - STALL -> STALL while the hazard persists; STALL -> RUN when it clears.
  - Any state -> FLUSH when ex_br_taken; FLUSH -> RUN next cycle, or FLUSH again if ex_br_taken is still high.
- Counters:
  - stall_cnt increments on each clock where the stall condition is asserted.
  - flush_cnt increments on each clock where ex_br_taken=1.
  - Both saturate at all-ones; neither wraps.
- Reset (async, rst_n low): shadow rd/wren = 0, FSM = RUN, stall_cnt = 0, flush_cnt = 0. A reset mid-stall aborts the stall immediately; after release, no hazard is reported until new EX writes appear.
- x0 never causes a hazard.
- A source used twice (rs1==rs2) gives a single stall, not an extended one.
- If EX and MEM both target the same rd, the stall lasts until the younger (EX) producer retires from the checked window.

Decomposition:
- Package hazard_pkg holds:
  - the opcode localparams: OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP;
  - functions uses_rs1(opcode) and uses_rs2(opcode);
  - the FSM state enum typedef hz_state_t {RUN, STALL, FLUSH}.
- One natural sub-module, sat_counter (parameterised width, inc input, async active-low reset), instantiated twice for the two counters.

Test Plan:
- addi x5 in EX (ex_rd=5, wren=1), then ID add x6,x5,x7 (opcode 01100, rs1=5) -> pc_stall/ifid_stall/idex_flush=1 for 3 cycles (2 with RF_WRITE_THROUGH=1), then 0; stall_cnt=3.
- ex_rd=0, wren=1 with ID rs1=0 -> no stall; stall_cnt stays 0.
- ID LUI (01101) with rs1 field=5 while ex_rd=5, wren=1 -> no stall, because rs1 is unused.
- ID store (01000) with rs2=9, MEM shadow rd=9 wren=1 -> 1-cycle stall (RF_WRITE_THROUGH=1).
- Hazard present and ex_br_taken=1 in the same cycle -> ifid_flush=idex_flush=1, pc_stall=0; flush_cnt +1; FSM=FLUSH then RUN.
- Drop rst_n for 1 cycle mid-stall -> controls 0 immediately, counters 0, shadows cleared; the next ID instruction proceeds with no stall.
- Force the counter to its maximum with CNT_W=4 (15 stall cycles), then keep stalling -> stall_cnt holds at 15.
